// File: rtl/plugboard.sv
// plugboard: runtime-configured symmetric letter-swap stage ahead of the rotor chain.
// Optional build macro PLUGBOARD_PASS_NONALPHA_EN: non-letters pass through unchanged
// instead of being dropped with a char_err pulse.
module plugboard #(
  parameter int unsigned MAX_PAIRS = 10,
  parameter int unsigned BASE      = 65
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_clear,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_a,
  input  logic [7:0] cfg_b,
  output logic       cfg_err,
  output logic [3:0] pair_cnt,
  input  logic       valid,
  input  logic [7:0] din,
  output logic       ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       char_err
);

  localparam logic [7:0] FIRST = 8'(BASE);
  localparam logic [7:0] LAST  = 8'(BASE + 25);
  localparam logic [3:0] FULL  = 4'(MAX_PAIRS);

`ifdef PLUGBOARD_PASS_NONALPHA_EN
  localparam logic PASS_NONALPHA = 1'b1;
`else
  localparam logic PASS_NONALPHA = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    OUT
  } state_t;

  state_t     state_q, state_d;

  logic [4:0] map_q [0:25];
  logic [3:0] cnt_q;
  logic       cfg_err_q;

  logic [7:0] din_r;
  logic [7:0] res_q;
  logic       ok_q;
  logic [7:0] dout_q;
  logic       dout_valid_q;
  logic       char_err_q;

  logic       din_is_letter;
  logic [4:0] din_idx;
  logic [7:0] lookup_res;

  logic       a_let, b_let;
  logic [4:0] a_idx, b_idx;
  logic       a_plugged, b_plugged;
  logic       cfg_slot;
  logic       cfg_accept;
  logic       cfg_reject;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one character every three cycles, no queuing
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (valid) state_d = LOOKUP;
      end
      LOOKUP:  state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Character lookup through the current table
  always_comb begin
    din_is_letter = (din_r >= FIRST) && (din_r <= LAST);
    din_idx       = '0;
    lookup_res    = din_r;
    if (din_is_letter) begin
      din_idx    = 5'(din_r - FIRST);
      lookup_res = FIRST + {3'b000, map_q[din_idx]};
    end
  end

  // Pair validation; indices are clamped to 0 for non-letters so the table is never read out of range
  always_comb begin
    a_let     = (cfg_a >= FIRST) && (cfg_a <= LAST);
    b_let     = (cfg_b >= FIRST) && (cfg_b <= LAST);
    a_idx     = a_let ? 5'(cfg_a - FIRST) : '0;
    b_idx     = b_let ? 5'(cfg_b - FIRST) : '0;
    a_plugged = (map_q[a_idx] != a_idx);
    b_plugged = (map_q[b_idx] != b_idx);
    cfg_slot  = (state_q == IDLE) && !valid;
    cfg_accept = cfg_valid && cfg_slot && a_let && b_let && (cfg_a != cfg_b)
                 && !a_plugged && !b_plugged && (cnt_q != FULL);
    cfg_reject = cfg_valid && !cfg_accept;
  end

  // Swap table, pair count and sticky configuration error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 26; i++) map_q[i] <= 5'(i);
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else if (cfg_clear) begin
      for (int unsigned i = 0; i < 26; i++) map_q[i] <= 5'(i);
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (cfg_accept) begin
        map_q[a_idx] <= b_idx;
        map_q[b_idx] <= a_idx;
        cnt_q        <= cnt_q + 4'd1;
      end
      if (cfg_reject) cfg_err_q <= 1'b1;
    end
  end

  // Character datapath: latch in IDLE, compute in LOOKUP, register outputs leaving OUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_r        <= '0;
      res_q        <= '0;
      ok_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      char_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      char_err_q   <= 1'b0;
      case (state_q)
        IDLE: if (valid) din_r <= din;
        LOOKUP: begin
          res_q <= lookup_res;
          ok_q  <= din_is_letter || PASS_NONALPHA;
        end
        OUT: begin
          dout_valid_q <= ok_q;
          char_err_q   <= !ok_q;
          if (ok_q) dout_q <= res_q;
        end
        default: ;
      endcase
    end
  end

  assign cfg_err    = cfg_err_q;
  assign pair_cnt   = cnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign char_err   = char_err_q;

endmodule

// File: tb/tb_plugboard.sv
// Self-checking bench for plugboard: vector table plus hand-written config/reset sequences,
// outputs scored against a queue of expected results.
module tb_plugboard;

  localparam int unsigned MP = 10;
  localparam int unsigned B  = 65;

  logic       clk;
  logic       reset_n;
  logic       cfg_clear;
  logic       cfg_valid;
  logic [7:0] cfg_a;
  logic [7:0] cfg_b;
  logic       cfg_err;
  logic [3:0] pair_cnt;
  logic       valid;
  logic [7:0] din;
  logic       ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       char_err;

  plugboard #(.MAX_PAIRS(MP), .BASE(B)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_clear  (cfg_clear),
    .cfg_valid  (cfg_valid),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_err    (cfg_err),
    .pair_cnt   (pair_cnt),
    .valid      (valid),
    .din        (din),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .char_err   (char_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] dout;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic       err;
    logic [7:0] dout;
  } vec_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;

  int         tb_map[26];
  int         tb_cnt;
  bit         tb_err;
  logic [7:0] last_dout;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_let(input logic [7:0] c);
    return (c >= 8'(B)) && (c <= 8'(B + 25));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 26; i++) tb_map[i] = i;
    tb_cnt = 0;
    tb_err = 1'b0;
  endfunction

  // Expected result for one character under the bench's table
  function automatic exp_t model_char(input logic [7:0] c);
    exp_t e;
    if (is_let(c)) begin
      e.err     = 1'b0;
      e.dout    = 8'(B + tb_map[c - 8'(B)]);
      last_dout = e.dout;
    end else begin
`ifdef PLUGBOARD_PASS_NONALPHA_EN
      e.err     = 1'b0;
      e.dout    = c;
      last_dout = c;
`else
      e.err     = 1'b1;
      e.dout    = last_dout;
`endif
    end
    return e;
  endfunction

  // Output monitor: every dout_valid/char_err pulse must match the head of the queue
  always @(posedge clk) begin
    #1;
    if (dout_valid || char_err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: dout_valid=%0d char_err=%0d dout=0x%0h, required no output",
                 dout_valid, char_err, dout);
      end else begin
        mon_e = q.pop_front();
        chk("out_dout_valid", int'(dout_valid), int'(!mon_e.err));
        chk("out_char_err", int'(char_err), int'(mon_e.err));
        chk("out_dout", int'(dout), int'(mon_e.dout));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  // Drive one character with a given expectation, then let it drain
  task automatic drive_char(input logic [7:0] c, input exp_t e);
    @(negedge clk);
    wait_ready();
    q.push_back(e);
    valid = 1'b1;
    din   = c;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c);
    exp_t e;
    e = model_char(c);
    drive_char(c, e);
  endtask

  // Request a pair; optionally also strobe a character in the same cycle
  task automatic cfg_pair(input logic [7:0] a, input logic [7:0] b, input bit with_valid);
    bit acc;
    exp_t e;
    @(negedge clk);
    wait_ready();
    acc = !with_valid && is_let(a) && is_let(b) && (a != b) && (tb_cnt < int'(MP));
    if (acc) acc = (tb_map[a - 8'(B)] == int'(a - 8'(B))) && (tb_map[b - 8'(B)] == int'(b - 8'(B)));
    cfg_valid = 1'b1;
    cfg_a     = a;
    cfg_b     = b;
    if (with_valid) begin
      e = model_char(8'h43);
      q.push_back(e);
      valid = 1'b1;
      din   = 8'h43;
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    valid     = 1'b0;
    if (acc) begin
      tb_map[a - 8'(B)] = int'(b - 8'(B));
      tb_map[b - 8'(B)] = int'(a - 8'(B));
      tb_cnt++;
    end else begin
      tb_err = 1'b1;
    end
    chk("cfg_err", int'(cfg_err), int'(tb_err));
    chk("pair_cnt", int'(pair_cnt), tb_cnt);
    if (with_valid) repeat (3) @(negedge clk);
  endtask

  task automatic clear_cfg();
    @(negedge clk);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    model_reset();
    chk("clear_cfg_err", int'(cfg_err), 0);
    chk("clear_pair_cnt", int'(pair_cnt), 0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h41, 1'b0, 8'h5A};
    vecs[1] = '{8'h5A, 1'b0, 8'h41};
    vecs[2] = '{8'h51, 1'b0, 8'h45};
    vecs[3] = '{8'h45, 1'b0, 8'h51};
    vecs[4] = '{8'h4D, 1'b0, 8'h4D};
`ifdef PLUGBOARD_PASS_NONALPHA_EN
    vecs[5] = '{8'h20, 1'b0, 8'h20};
    vecs[6] = '{8'h42, 1'b0, 8'h42};
    vecs[7] = '{8'h5B, 1'b0, 8'h5B};
    vecs[8] = '{8'h40, 1'b0, 8'h40};
`else
    vecs[5] = '{8'h20, 1'b1, 8'h4D};
    vecs[6] = '{8'h42, 1'b0, 8'h42};
    vecs[7] = '{8'h5B, 1'b1, 8'h42};
    vecs[8] = '{8'h40, 1'b1, 8'h42};
`endif
    vecs[9] = '{8'h59, 1'b0, 8'h59};

    reset_n   = 1'b0;
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    cfg_a     = '0;
    cfg_b     = '0;
    valid     = 1'b0;
    din       = '0;
    model_reset();
    last_dout = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", int'(ready), 1);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_char_err", int'(char_err), 0);
    chk("rst_pair_cnt", int'(pair_cnt), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);

    // Latency and ready timing for one identity character
    @(negedge clk);
    q.push_back(model_char(8'h51));
    valid = 1'b1;
    din   = 8'h51;
    @(posedge clk);
    #1 chk("lat_ready_lookup", int'(ready), 0);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_ready_out", int'(ready), 0);
    chk("lat_no_early_valid", int'(dout_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_ready_back", int'(ready), 1);
    chk("lat_dout_valid", int'(dout_valid), 1);
    @(posedge clk);
    #1;
    chk("lat_single_pulse", int'(dout_valid), 0);
    chk("lat_dout_hold", int'(dout), 8'h51);
    last_dout = 8'h51;

    // Two pairs, then the vector table
    cfg_pair(8'h41, 8'h5A, 1'b0);
    cfg_pair(8'h45, 8'h51, 1'b0);
    chk("two_pairs_cnt", int'(pair_cnt), 2);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.err  = vecs[i].err;
      e.dout = vecs[i].dout;
      drive_char(vecs[i].din, e);
    end
    last_dout = 8'h59;

    // Conflicting pair rejected, table unchanged, then clear
    cfg_pair(8'h41, 8'h42, 1'b0);
    chk("conflict_err", int'(cfg_err), 1);
    chk("conflict_cnt", int'(pair_cnt), 2);
    send_char(8'h42);
    clear_cfg();
    send_char(8'h41);

    // Fill to MAX_PAIRS, one more is rejected
    for (int k = 0; k <= int'(MP); k++) cfg_pair(8'(B + 2 * k), 8'(B + 2 * k + 1), 1'b0);
    chk("full_err", int'(cfg_err), 1);
    chk("full_cnt", int'(pair_cnt), int'(MP));
    send_char(8'h41);
    send_char(8'h55);

    // Same letter twice, non-letter byte, and config alongside a character
    clear_cfg();
    cfg_pair(8'h4B, 8'h4B, 1'b0);
    clear_cfg();
    cfg_pair(8'h20, 8'h41, 1'b0);
    clear_cfg();
    cfg_pair(8'h43, 8'h44, 1'b1);
    send_char(8'h43);

    // Strobe during LOOKUP is ignored
    clear_cfg();
    cfg_pair(8'h41, 8'h5A, 1'b0);
    @(negedge clk);
    q.push_back(model_char(8'h41));
    valid = 1'b1;
    din   = 8'h41;
    @(negedge clk);
    din = 8'h4D;
    @(negedge clk);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignored_queue_empty", q.size(), 0);

    // Reset while a character is in LOOKUP
    cfg_pair(8'h43, 8'h44, 1'b0);
    cfg_pair(8'h4B, 8'h4B, 1'b0);
    @(negedge clk);
    valid = 1'b1;
    din   = 8'h43;
    @(negedge clk);
    valid   = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    last_dout = 8'h00;
    chk("midrst_pair_cnt", int'(pair_cnt), 0);
    chk("midrst_cfg_err", int'(cfg_err), 0);
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_dout", int'(dout), 0);
    repeat (5) @(negedge clk);
    send_char(8'h43);
    send_char(8'h41);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plugboard.md
Name: plugboard

Overview:
- Plugboard stage directly upstream of the rotor chain.
- Holds a runtime-configured table of up to MAX_PAIRS letter swaps and maps each incoming ASCII uppercase character through it.
- Presents the result to the first rotor as a one-cycle valid pulse plus data byte.
- Swaps are symmetric, so the same table serves the return path when the block is reused after the reflector.

Parameters:
MAX_PAIRS, 10, maximum number of plugged pairs accepted (legal range 1..13)
BASE, 65, ASCII code of 'A'; letters are BASE..BASE+25

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cfg_clear  input  1  restore identity table, clear pair count and cfg_err
cfg_valid  input  1  request to plug pair (cfg_a, cfg_b)
cfg_a  input  8  first letter of pair (ASCII)
cfg_b  input  8  second letter of pair (ASCII)
cfg_err  output  1  sticky configuration error flag
pair_cnt  output  4  number of pairs currently plugged
valid  input  1  input character strobe
din  input  8  input character (ASCII)
ready  output  1  block can accept a character this cycle
dout  output  8  mapped character, drives rotor din
dout_valid  output  1  one-cycle pulse, drives rotor valid
char_err  output  1  one-cycle pulse: din was not a letter and was dropped

Behaviour:
- One clock (clk); reset_n is asynchronous, active-low.
- Reset (asynchronous, any time including mid-character):
  - table = identity (map[i]=i for i=0..25); pair_cnt=0; cfg_err=0.
  - state=IDLE; dout=8'h00; dout_valid=0; char_err=0; ready=1 after deassertion.
- Table: 26 entries of 5 bits, index = letter-BASE. An entry is "plugged" when map[i]!=i.
- FSM:
  - IDLE: ready=1. valid=1 latches din into din_r, goes to LOOKUP.
  - LOOKUP: ready=0. Computes the result into a register, goes to OUT.
  - OUT: ready=0. Exactly one of dout_valid or char_err is high for this single cycle, then back to IDLE.
- Latency: valid sampled at edge N → dout_valid high in the cycle after edge N+2. Throughput is one character per 3 cycles.
- valid while ready=0 is ignored: no queuing, no error.
- Mapping:
  - din in BASE..BASE+25 → dout = BASE + map[din-BASE], dout_valid=1.
  - Otherwise → char_err=1, dout_valid=0, dout unchanged.
- dout holds its last value between OUT cycles.
- Configuration, evaluated on the clock edge:
  - cfg_clear has priority over cfg_valid in the same cycle. The table update takes effect next cycle.
  - cfg_valid is accepted only in IDLE, and only when valid=0 in the same cycle. Otherwise it is rejected: cfg_err is set and the table is unchanged.
  - Rejection conditions: either byte not a letter; cfg_a==cfg_b; either letter already plugged; pair_cnt==MAX_PAIRS. Any of these sets cfg_err; table and pair_cnt are unchanged.
  - Accepted pair: map[a]=b, map[b]=a, pair_cnt+1.
- cfg_err is sticky; only cfg_clear or reset clears it.
- A character in flight (LOOKUP/OUT) uses the table as it stood when it was latched. No config write can occur then, since config is accepted only in IDLE.
- pair_cnt never exceeds MAX_PAIRS. Width is 4 bits for MAX_PAIRS≤13.

Optional Feature:
- Macro: PLUGBOARD_PASS_NONALPHA_EN.
- Defined: a non-letter din passes through unchanged. dout=din, dout_valid=1, and char_err is tied 0. Spaces and punctuation therefore reach the rotor.
- Undefined: non-letters are dropped with a char_err pulse, as described in Behaviour.

Test Plan:
- Reset, then valid=1 with din='Q' (0x51) → ready low for 2 cycles; dout_valid pulses once 3 cycles after valid with dout=0x51; ready returns to 1.
- Plug ('A','Z') and ('E','Q') → pair_cnt=2. din='A' gives dout='Z' (0x5A); din='Q' gives dout='E' (0x45); din='M' gives dout='M'.
- Plug ('A','B') after ('A','Z') → cfg_err=1, pair_cnt stays 2, 'B' still maps to 'B'. Then cfg_clear → cfg_err=0, pair_cnt=0, 'A' maps to 'A'.
- Plug MAX_PAIRS+1 distinct pairs → the last is rejected, cfg_err=1, pair_cnt=MAX_PAIRS. Also cfg_valid with cfg_a=cfg_b='K' → rejected.
- din=0x20 → char_err pulse, no dout_valid, dout unchanged (macro undefined). With PLUGBOARD_PASS_NONALPHA_EN: dout_valid with dout=0x20.
- Assert reset_n=0 during LOOKUP after plugging pairs → dout_valid never pulses, table is identity, pair_cnt=0, ready=1 after release. Also pulse valid again while in LOOKUP → no second dout_valid.
